mc_main_ctrl: RTL
=================

// Module: mc_main_ctrl
// PURPOSE
//  Multi-cycle MIPS main control FSM. Decodes the IR opcode and sequences datapath enables.
//  Drives alu_op_o[2:0], the ALUOp input of the ALU controller.
//  Handshakes with a variable-latency memory and counts retired instructions.
// PARAMETERS
//  CNT_W      32   width of retired-instruction counter
// PORTS
//  clk_i         in   1      clock, rising edge
//  rst_i         in   1      synchronous reset, active-high
//  instr_op_i    in   6      IR[31:26] opcode
//  zero_i        in   1      ALU zero flag (valid in BRANCH)
//  mem_ready_i   in   1      memory completes current read/write this cycle
//  pc_write_o    out  1      PC load enable
//  iord_o        out  1      0 = address from PC, 1 = from ALUOut
//  mem_read_o    out  1      memory read request
//  mem_write_o   out  1      memory write request
//  ir_write_o    out  1      IR load enable
//  reg_dst_o     out  1      1 = rd, 0 = rt
//  mem_to_reg_o  out  1      1 = MDR, 0 = ALUOut
//  reg_write_o   out  1      register-file write enable
//  alu_src_a_o   out  1      0 = PC, 1 = rs
//  alu_src_b_o   out  2      0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sext imm<<2
//  pc_src_o      out  2      0 = ALU result, 1 = ALUOut, 2 = jump target
//  alu_op_o      out  3      0 = add, 1 = sub, 2 = R-type/funct, 3 = slt
//  state_o       out  4      current state code (debug)
//  illegal_o     out  1      sticky illegal-opcode flag
//  retired_o     out  CNT_W  retired-instruction count
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7,
//   BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12.
//  Reset (rst_i=1 at edge): state=FETCH, illegal_o=0, retired_o=0.
//   While rst_i=1, every control output is forced to 0.
//  All outputs are Moore decodes of state, except where gated by mem_ready_i or zero_i.
//   Unlisted outputs are 0 in each state.
//  FETCH:    mem_read=1, alu_src_b=1, alu_op=0. Holds while mem_ready_i=0.
//            On mem_ready_i=1: ir_write=1, pc_write=1 (pc_src=0), next DECODE.
//  DECODE:   alu_src_b=3, alu_op=0. Latches instr_op_i into op_q.
//            Next state by opcode: 0x00 R_EXEC; 0x23/0x2B MEM_ADDR; 0x04/0x05 BRANCH;
//            0x02 JUMP; 0x08 I_EXEC (addi); 0x0A I_EXEC (slti); other -> TRAP.
//  MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next MEM_RD (op_q=0x23) or MEM_WR.
//  MEM_RD:   iord=1, mem_read=1. Wait on mem_ready_i, then MEM_WB.
//  MEM_WB:   reg_write=1, mem_to_reg=1, reg_dst=0. Retire, then FETCH.
//  MEM_WR:   iord=1, mem_write=1. Wait on mem_ready_i. On ready: retire, then FETCH.
//  R_EXEC:   alu_src_a=1, alu_op=2. Next R_WB.
//  R_WB:     reg_write=1, reg_dst=1. Retire, then FETCH.
//  BRANCH:   alu_src_a=1, alu_op=1, pc_src=1.
//            pc_write = (op_q=0x04 & zero_i) | (op_q=0x05 & ~zero_i). Retire, then FETCH.
//  JUMP:     pc_write=1, pc_src=2. Retire, then FETCH.
//  I_EXEC:   alu_src_a=1, alu_src_b=2. alu_op=0 for addi, 3 for slti. Next I_WB.
//  I_WB:     reg_write=1, reg_dst=0. Retire, then FETCH.
//  TRAP:     all enables 0; illegal_o=1 from the cycle after entry. Exit only by reset.
//  Retire: retired_o increments by 1 on the exiting edge; wraps 2^CNT_W-1 -> 0.
//  Memory handshake: a request stays asserted, with address source stable, until mem_ready_i=1.
//   mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR.
//  Reset in any state (including a pending memory wait) aborts the instruction.
//   No retire on that cycle; next state is FETCH.
//  Cycle counts with zero-wait memory: lw 5, sw 4, R/addi/slti 4, beq/bne 3, j 3.
// TESTING
//  lw (0x23), mem_ready_i=1 always -> states 0,1,2,3,4,0; alu_op 0 throughout; retired_o 0->1.
//  R-type (0x00) -> states 0,1,6,7; alu_op=2 in R_EXEC; reg_write=1, reg_dst=1 in R_WB.
//  beq with zero_i=1 -> pc_write=1 in BRANCH; bne with zero_i=1 -> pc_write=0; both retire.
//  FETCH with mem_ready_i low for 3 cycles -> state stays 0, mem_read=1, ir_write=0;
//   ir_write=1 only in cycle 4.
//  slti (0x0A) -> alu_op=3 in I_EXEC. Opcode 0x3F -> TRAP; illegal_o=1 held 20 cycles; reset clears.
//  Reset during MEM_RD wait -> FETCH next cycle, retired_o unchanged, outputs 0 during reset.

Source files
------------

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: decodes the IR opcode, sequences datapath
// enables, handshakes with a variable-latency memory and counts retired instructions.
`timescale 1ns/1ps
module mc_main_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       pc_src_o,
  output logic [2:0]       alu_op_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_FN  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  ctrl_t            ctrl;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= instr_op_i;
      if (state_q == S_TRAP) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // NOTE: every signal driven here gets its default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'd1;
        ctrl.alu_op    = ALU_ADD;
        if (mem_ready_i) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'd3;
        ctrl.alu_op    = ALU_ADD;
        case (instr_op_i)
          OP_RTYPE:        state_d = S_R_EXEC;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ADDI,
          OP_SLTI:         state_d = S_I_EXEC;
          default:         state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'd2;
        ctrl.alu_op    = ALU_ADD;
        state_d        = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        retire          = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        if (mem_ready_i) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FN;
        state_d        = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = 2'd1;
        ctrl.pc_write  = ((op_q == OP_BEQ) && zero_i) || ((op_q == OP_BNE) && !zero_i);
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 2'd2;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'd2;
        ctrl.alu_op    = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d        = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset overrides the decode so no enable leaks out while the FSM is being reset.
  ctrl_t ctrl_out;
  assign ctrl_out = rst_i ? ctrl_t'('0) : ctrl;

  assign pc_write_o   = ctrl_out.pc_write;
  assign iord_o       = ctrl_out.iord;
  assign mem_read_o   = ctrl_out.mem_read;
  assign mem_write_o  = ctrl_out.mem_write;
  assign ir_write_o   = ctrl_out.ir_write;
  assign reg_dst_o    = ctrl_out.reg_dst;
  assign mem_to_reg_o = ctrl_out.mem_to_reg;
  assign reg_write_o  = ctrl_out.reg_write;
  assign alu_src_a_o  = ctrl_out.alu_src_a;
  assign alu_src_b_o  = ctrl_out.alu_src_b;
  assign pc_src_o     = ctrl_out.pc_src;
  assign alu_op_o     = ctrl_out.alu_op;
  assign state_o      = state_q;
  assign illegal_o    = illegal_q;
  assign retired_o    = retired_q;

endmodule
